// File: rtl/data_memory_pkg.sv
// Shared constants and types for the data memory block.
// Holds the RV32I load/store width codes and the FSM state enum.
package data_memory_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane extract/insert and request error check.
// Loads are sign/zero-extended; stores merge into the current word.
module lsu_align
    import data_memory_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic        error,
    output logic [31:0] new_word,
    output logic [31:0] rdata
);

    logic is_b;
    logic is_h;
    logic is_w;
    logic is_bu;
    logic is_hu;
    logic bad_f3;
    logic mis;
    logic oor;
    logic [4:0] b_sh;
    logic [4:0] h_sh;
    logic [7:0] b_val;
    logic [15:0] h_val;

    assign is_b  = (funct3 == F3_B);
    assign is_h  = (funct3 == F3_H);
    assign is_w  = (funct3 == F3_W);
    assign is_bu = (funct3 == F3_BU);
    assign is_hu = (funct3 == F3_HU);

    assign b_sh  = {addr[1:0], 3'b000};
    assign h_sh  = {addr[1], 4'b0000};
    assign b_val = word[b_sh +: 8];
    assign h_val = word[h_sh +: 16];

    // Legality: width code, natural alignment, address range.
    always_comb begin
        bad_f3 = write ? !(is_b | is_h | is_w)
                       : !(is_b | is_h | is_w | is_bu | is_hu);
        mis    = ((is_h | is_hu) & addr[0]) | (is_w & (|addr[1:0]));
        oor    = (addr >= 32'(4 * DEPTH));
        error  = bad_f3 | mis | oor;
    end

    // Load lane select and extension; zero for stores and errors.
    always_comb begin
        rdata = '0;
        if (!write && !error) begin
            unique case (1'b1)
                is_b:    rdata = {{24{b_val[7]}}, b_val};
                is_bu:   rdata = {24'b0, b_val};
                is_h:    rdata = {{16{h_val[15]}}, h_val};
                is_hu:   rdata = {16'b0, h_val};
                is_w:    rdata = word;
                default: rdata = '0;
            endcase
        end
    end

    // Store lane merge into the existing word.
    always_comb begin
        new_word = word;
        if (write) begin
            unique case (1'b1)
                is_b:    new_word[b_sh +: 8]  = wdata[7:0];
                is_h:    new_word[h_sh +: 16] = wdata[15:0];
                is_w:    new_word = wdata;
                default: new_word = word;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with fixed access latency.
// One request in flight; valid/ready on both request and response.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = $clog2(DEPTH);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic        accept;
    logic        access;

    logic        q_write;
    logic [2:0]  q_f3;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;

    logic        a_write;
    logic [2:0]  a_f3;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [AW-1:0] a_idx;
    logic [31:0] a_word;
    logic        al_err;
    logic [31:0] al_new;
    logic [31:0] al_rdata;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        error_q;

    assign req_ready = (state == IDLE) & ~reset;
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == RESP) & ~reset;
    assign rsp_rdata = reset ? '0 : rdata_q;
    assign rsp_error = error_q & ~reset;

    // Zero latency accesses straight from the request port.
    assign a_write = (state == IDLE) ? req_write  : q_write;
    assign a_f3    = (state == IDLE) ? req_funct3 : q_f3;
    assign a_addr  = (state == IDLE) ? req_addr   : q_addr;
    assign a_wdata = (state == IDLE) ? req_wdata  : q_wdata;
    assign a_idx   = a_addr[AW+1:2];
    assign a_word  = mem[a_idx];

    lsu_align #(
        .DEPTH(DEPTH)
    ) u_align (
        .write    (a_write),
        .funct3   (a_f3),
        .addr     (a_addr),
        .wdata    (a_wdata),
        .word     (a_word),
        .error    (al_err),
        .new_word (al_new),
        .rdata    (al_rdata)
    );

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state; access fires on the edge that enters RESP.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                        access   = 1'b1;
                    end else begin
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                    access   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture request fields on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_write <= 1'b0;
            q_f3    <= '0;
            q_addr  <= '0;
            q_wdata <= '0;
        end else if (accept) begin
            q_write <= req_write;
            q_f3    <= req_funct3;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
        end
    end

    // Storage array and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (access) begin
            if (a_write && !al_err) begin
                mem[a_idx] <= al_new;
            end
            rdata_q <= al_rdata;
            error_q <= al_err;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed steps plus random
// loads/stores against a byte-array reference model.
module tb_data_memory;

    localparam int DEPTH = 32;
    localparam int LAT   = 2;
    localparam int NB    = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int total = 0;
    int bad   = 0;

    logic [7:0] mb [NB];

    data_memory #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    endfunction

    // Reference: little-endian byte array, natural alignment rules.
    function automatic void model(input logic w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic er);
        int sz;
        bit sgn;
        bit ok;
        longint unsigned v;
        sz = 1; sgn = 0; ok = 1;
        case (f3)
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: sz = 4;
            3'd4: begin sz = 1; ok = !w; end
            3'd5: begin sz = 2; ok = !w; end
            default: ok = 0;
        endcase
        er = !ok || (a >= 32'(NB)) || ((int'(a[1:0]) % sz) != 0);
        rd = 32'h0;
        if (er) return;
        if (w) begin
            for (int i = 0; i < sz; i++) mb[int'(a) + i] = d[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++)
                v = v | (longint'(mb[int'(a) + i]) << (8 * i));
            if (sgn && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 1);
            rd = v[31:0];
        end
    endfunction

    task automatic txn(input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd,
                       output logic er, output int lat);
        int g;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        rsp_ready  = (hold == 0);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("accept_wait", 32'(g < 20), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        rd = rsp_rdata;
        er = rsp_error;
        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                chk("hold.valid", 32'(rsp_valid), 32'd1);
                chk("hold.rdata", rsp_rdata, rd);
                chk("hold.req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            chk("hold.no_turn", 32'(req_ready), 32'd0);
            @(negedge clk);
            chk("hold.release", 32'(req_ready), 32'd1);
            chk("hold.valid_drop", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic op(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] erd, input logic eer, input int hold);
        logic [31:0] rd;
        logic er;
        int lat;
        txn(w, f3, a, d, hold, rd, er, lat);
        chk({tag, ".rdata"}, rd, erd);
        chk({tag, ".error"}, 32'(er), 32'(eer));
        chk({tag, ".lat"}, 32'(lat), 32'(LAT + 1));
    endtask

    // Run the reference then the DUT, checking against given constants.
    task automatic dop(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eer, input int hold);
        logic [31:0] mrd;
        logic mer;
        model(w, f3, a, d, mrd, mer);
        op(tag, w, f3, a, d, erd, eer, hold);
    endtask

    initial begin
        logic [31:0] mrd;
        logic mer;
        logic w;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] d;
        int g;
        int seen;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        model_clear();

        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_error", 32'(rsp_error), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst.ready_after", 32'(req_ready), 32'd1);

        dop("sw8",   1, 3'd2, 32'h8, 32'hDEADBEEF, 32'h0, 0, 0);
        dop("lw8",   0, 3'd2, 32'h8, 32'h0, 32'hDEADBEEF, 0, 0);
        dop("lbB",   0, 3'd0, 32'hB, 32'h0, 32'hFFFFFFDE, 0, 0);
        dop("lbuB",  0, 3'd4, 32'hB, 32'h0, 32'h000000DE, 0, 0);
        dop("lhA",   0, 3'd1, 32'hA, 32'h0, 32'hFFFFDEAD, 0, 0);
        dop("lhu8",  0, 3'd5, 32'h8, 32'h0, 32'h0000BEEF, 0, 0);
        dop("sb9",   1, 3'd0, 32'h9, 32'h12, 32'h0, 0, 0);
        dop("lw8b",  0, 3'd2, 32'h8, 32'h0, 32'hDEAD12EF, 0, 0);
        dop("lw6",   0, 3'd2, 32'h6, 32'h0, 32'h0, 1, 0);
        dop("sh5",   1, 3'd1, 32'h5, 32'hFFFF, 32'h0, 1, 0);
        dop("lw80",  0, 3'd2, 32'h80, 32'h0, 32'h0, 1, 0);
        dop("lw4",   0, 3'd2, 32'h4, 32'h0, 32'h0, 0, 0);
        dop("ld011", 0, 3'd3, 32'h8, 32'h0, 32'h0, 1, 0);
        dop("st100", 1, 3'd4, 32'h8, 32'hAA, 32'h0, 1, 0);
        dop("lw8c",  0, 3'd2, 32'h8, 32'h0, 32'hDEAD12EF, 0, 0);
        dop("hold",  0, 3'd2, 32'h8, 32'h0, 32'hDEAD12EF, 0, 5);

        // Reset one cycle after accepting a store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h0;
        req_wdata  = 32'h55;
        rsp_ready  = 1'b1;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_busy.ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst_busy.no_rsp", 32'(seen), 32'd0);
        dop("rst_busy.lw0", 0, 3'd2, 32'h0, 32'h0, 32'h0, 0, 0);
        dop("lw8_cleared", 0, 3'd2, 32'h8, 32'h0, 32'h0, 0, 0);

        // Reset while a committed store's response is pending.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        req_wdata  = 32'h77;
        rsp_ready  = 1'b0;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        g = 0;
        while (!rsp_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("rst_resp.reached", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_resp.valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp.rdata", rsp_rdata, 32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        model_clear();
        dop("rst_resp.lw10", 0, 3'd2, 32'h10, 32'h0, 32'h0, 0, 0);

        // Random traffic against the reference.
        for (int n = 0; n < 80; n++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, NB + 8));
            if (n % 4 == 0) a = $urandom;
            d  = $urandom;
            model(w, f3, a, d, mrd, mer);
            op("rand", w, f3, a, d, mrd, mer, (n % 9 == 0) ? 3 : 0);
        end

        // Final sweep: every word must match the reference.
        for (int i = 0; i < DEPTH; i++) begin
            model(0, 3'd2, 32'(4 * i), 32'h0, mrd, mer);
            op("sweep", 0, 3'd2, 32'(4 * i), 32'h0, mrd, mer, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
